// File: rtl/arithmetic_executor_pkg.sv
// Shared encodings for the arithmetic decoder / executor boundary.
// ALU op codes, operand-B sources, destination one-hots and executor FSM states.
// Any change here must be mirrored in the decoder that drives the control word.
package arithmetic_executor_pkg;

  // ALU operation select; codes with bit 2 set are illegal
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;

  // Operand B source select
  localparam logic [1:0] BSEL_EXT = 2'b00;
  localparam logic [1:0] BSEL_B   = 2'b01;
  localparam logic [1:0] BSEL_C   = 2'b10;
  localparam logic [1:0] BSEL_D   = 2'b11;

  // Destination register one-hots
  localparam logic [3:0] DEST_A = 4'b0001;
  localparam logic [3:0] DEST_B = 4'b0010;
  localparam logic [3:0] DEST_C = 4'b0100;
  localparam logic [3:0] DEST_D = 4'b1000;

  // Executor FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_ITER = 2'b10,
    ST_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/arithmetic_executor_iter_core.sv
// Iterative MUL (shift-add) / DIV (restoring) datapath, one bit per cycle.
// Latency: DATA_W steps after load; last flags the cycle whose step is final.
// No backpressure: steps every cycle after load, the caller samples lo/hi on last.
module arith_iter_core
  import arithmetic_executor_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              is_div,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              last
);

  // lo_q: multiplier (MUL) or dividend/quotient (DIV); hi_q: partial product or remainder
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] b_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q;

  logic [DATA_W:0] mul_sum;
  logic [DATA_W:0] rem_sh;
  logic [DATA_W:0] rem_try;

  // One iteration step; lo/hi expose the post-step value so the final step can be captured directly
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    rem_sh  = {hi_q, lo_q[DATA_W-1]};
    rem_try = rem_sh - {1'b0, b_q};
    cnt_d   = cnt_q + CNT_W'(1);
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (div_q) begin
      // Remainder stays below the divisor, so bit DATA_W of rem_try is a clean borrow
      if (!rem_try[DATA_W]) begin
        hi_d = rem_try[DATA_W-1:0];
        lo_d = {lo_q[DATA_W-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[DATA_W-1:0];
        lo_d = {lo_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      hi_d = mul_sum[DATA_W:1];
      lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
    end
  end

  // Load operands on launch, otherwise advance one step per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      lo_q  <= is_div ? op_a : op_b;
      hi_q  <= '0;
      b_q   <= is_div ? op_b : op_a;
      cnt_q <= '0;
      div_q <= is_div;
    end else begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      cnt_q <= cnt_d;
    end
  end

  assign lo   = lo_d;
  assign hi   = hi_d;
  assign last = (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/arithmetic_executor.sv
// ALU control-word executor: ADD/SUB single cycle, MUL/DIV iterative via arith_iter_core.
// Latency: done one cycle after start for ADD/SUB/illegal/div-by-zero, DATA_W+1 for MUL/DIV.
// start is only honoured in IDLE; starts while busy or in the done cycle are dropped.
module arithmetic_executor
  import arithmetic_executor_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        alu_sel,
  input  logic              acc_sel,
  input  logic [1:0]        alu_b_sel,
  input  logic [3:0]        destination_reg_flag,
  input  logic [DATA_W-1:0] reg_a,
  input  logic [DATA_W-1:0] reg_b,
  input  logic [DATA_W-1:0] reg_c,
  input  logic [DATA_W-1:0] reg_d,
  input  logic [DATA_W-1:0] ext_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] result_hi,
  output logic [3:0]        wr_en,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              flag_dz,
  output logic              flag_illegal
);

  state_e            state_q;
  logic              busy_q, done_q;
  logic [DATA_W-1:0] result_q, result_hi_q;
  logic [3:0]        wr_en_q, dest_q;
  logic              zero_q, carry_q, dz_q, ill_q, div_q;

  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W:0]   add_w, sub_w;
  logic              iter_go, core_load, core_last;
  logic [DATA_W-1:0] core_lo, core_hi;

  // Operand selection and the single-cycle ADD/SUB datapath
  always_comb begin
    op_a = acc_sel ? ext_data : reg_a;
    case (alu_b_sel)
      BSEL_B:  op_b = reg_b;
      BSEL_C:  op_b = reg_c;
      BSEL_D:  op_b = reg_d;
      default: op_b = ext_data;
    endcase
    add_w     = {1'b0, op_a} + {1'b0, op_b};
    sub_w     = {1'b0, op_a} - {1'b0, op_b};
    iter_go   = (alu_sel == ALU_MUL) || ((alu_sel == ALU_DIV) && (op_b != '0));
    core_load = (state_q == ST_IDLE) && start && iter_go;
  end

  arith_iter_core #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .is_div (alu_sel == ALU_DIV),
    .op_a   (op_a),
    .op_b   (op_b),
    .lo     (core_lo),
    .hi     (core_hi),
    .last   (core_last)
  );

  // Control FSM with registered status/result outputs; done and wr_en pulse for one cycle only
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      wr_en_q     <= '0;
      dest_q      <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      dz_q        <= 1'b0;
      ill_q       <= 1'b0;
      div_q       <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= '0;
      case (state_q)
        ST_IDLE: if (start) begin
          busy_q <= 1'b1;
          dest_q <= destination_reg_flag;
          div_q  <= (alu_sel == ALU_DIV);
          if (iter_go) begin
            state_q <= ST_ITER;
          end else begin
            // Everything not iterative finishes here: ADD, SUB, div-by-zero, illegal
            state_q     <= ST_EXEC;
            done_q      <= 1'b1;
            wr_en_q     <= destination_reg_flag;
            result_hi_q <= '0;
            dz_q        <= 1'b0;
            ill_q       <= 1'b0;
            carry_q     <= 1'b0;
            case (alu_sel)
              ALU_ADD: begin
                result_q <= add_w[DATA_W-1:0];
                carry_q  <= add_w[DATA_W];
                zero_q   <= (add_w[DATA_W-1:0] == '0);
              end
              ALU_SUB: begin
                result_q <= sub_w[DATA_W-1:0];
                carry_q  <= sub_w[DATA_W];
                zero_q   <= (sub_w[DATA_W-1:0] == '0);
              end
              ALU_DIV: begin
                result_q    <= '1;
                result_hi_q <= op_a;
                dz_q        <= 1'b1;
                zero_q      <= 1'b0;
              end
              default: begin
                result_q <= '0;
                zero_q   <= 1'b1;
                ill_q    <= 1'b1;
                wr_en_q  <= '0;
              end
            endcase
          end
        end
        ST_ITER: if (core_last) begin
          state_q     <= ST_DONE;
          done_q      <= 1'b1;
          wr_en_q     <= dest_q;
          result_q    <= core_lo;
          result_hi_q <= core_hi;
          zero_q      <= (core_lo == '0);
          carry_q     <= div_q ? 1'b0 : (core_hi != '0);
          dz_q        <= 1'b0;
          ill_q       <= 1'b0;
        end
        default: begin
          // EXEC and DONE both last one cycle and hand back to IDLE
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign result_hi    = result_hi_q;
  assign wr_en        = wr_en_q;
  assign flag_zero    = zero_q;
  assign flag_carry   = carry_q;
  assign flag_dz      = dz_q;
  assign flag_illegal = ill_q;

endmodule

// File: tb/tb_arithmetic_executor.sv
// Scoreboard bench for arithmetic_executor: directed vectors push expectations,
// a negedge monitor checks busy every cycle and pops/compares on each done pulse.
// Cycle k is the one following clock edge k-1; cyc holds the index of the last edge.
module tb_arithmetic_executor;
  import arithmetic_executor_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, acc_sel;
  logic [2:0] alu_sel;
  logic [1:0] alu_b_sel;
  logic [3:0] destination_reg_flag;
  logic [7:0] reg_a, reg_b, reg_c, reg_d, ext_data;
  logic       busy, done, flag_zero, flag_carry, flag_dz, flag_illegal;
  logic [7:0] result, result_hi;
  logic [3:0] wr_en;

  typedef struct {
    int         n;
    int         lat;
    logic [7:0] res;
    logic [7:0] hi;
    logic [3:0] wr;
    logic       z, cy, dz, il;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;

  arithmetic_executor dut (
    .clk(clk), .rst(rst), .start(start), .alu_sel(alu_sel), .acc_sel(acc_sel),
    .alu_b_sel(alu_b_sel), .destination_reg_flag(destination_reg_flag),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d), .ext_data(ext_data),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi), .wr_en(wr_en),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_dz(flag_dz),
    .flag_illegal(flag_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Monitor: busy must track outstanding work; every done must match the head of the scoreboard
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("busy", busy, (sb.size() != 0) && (cyc >= sb[0].n));
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.n + e.lat - 1);
          chk("result", result, e.res);
          chk("result_hi", result_hi, e.hi);
          chk("wr_en", wr_en, e.wr);
          chk("flag_zero", flag_zero, e.z);
          chk("flag_carry", flag_carry, e.cy);
          chk("flag_dz", flag_dz, e.dz);
          chk("flag_illegal", flag_illegal, e.il);
        end
      end else begin
        chk("wr_en_idle", wr_en, 4'b0000);
      end
    end
  end

  // Drive one control word for a single start edge, then scramble inputs to prove they were latched
  task automatic issue(input logic [2:0] sel, input logic asel, input logic [1:0] bsel,
                       input logic [3:0] dst, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input logic [7:0] e,
                       input int lat, input logic [7:0] res, input logic [7:0] hi,
                       input logic [3:0] wr, input logic z, input logic cy,
                       input logic dz, input logic il);
    exp_t x;
    @(negedge clk);
    alu_sel = sel; acc_sel = asel; alu_b_sel = bsel; destination_reg_flag = dst;
    reg_a = a; reg_b = b; reg_c = c; reg_d = d; ext_data = e;
    start = 1'b1;
    x.n = cyc + 1; x.lat = lat; x.res = res; x.hi = hi; x.wr = wr;
    x.z = z; x.cy = cy; x.dz = dz; x.il = il;
    sb.push_back(x);
    @(posedge clk);
    #1;
    start = 1'b0;
    reg_a = ~a; reg_b = ~b; reg_c = ~c; reg_d = ~d; ext_data = ~e;
    alu_sel = sel ^ 3'b001; acc_sel = ~asel; alu_b_sel = ~bsel; destination_reg_flag = ~dst;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout_%s: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; alu_sel = '0; acc_sel = 1'b0; alu_b_sel = '0;
    destination_reg_flag = '0; reg_a = '0; reg_b = '0; reg_c = '0; reg_d = '0; ext_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, 8'h00);
    chk("rst_result_hi", result_hi, 8'h00);
    chk("rst_wr_en", wr_en, 4'h0);
    chk("rst_flags", {flag_zero, flag_carry, flag_dz, flag_illegal}, 4'b0000);
    rst = 1'b0;
    mon_en = 1'b1;

    //    sel      as    bsel      dest    a      b      c      d      ext    lat res    hi     wr     z  cy dz il
    issue(ALU_ADD, 1'b0, BSEL_B,   DEST_A, 8'hF0, 8'h20, 8'h00, 8'h00, 8'h00, 1, 8'h10, 8'h00, DEST_A, 0, 1, 0, 0);
    wait_done("add");
    issue(ALU_SUB, 1'b0, BSEL_C,   DEST_B, 8'h05, 8'h00, 8'h07, 8'h00, 8'h00, 1, 8'hFE, 8'h00, DEST_B, 0, 1, 0, 0);
    wait_done("sub");
    issue(ALU_MUL, 1'b0, BSEL_D,   DEST_C, 8'h0C, 8'h00, 8'h00, 8'h15, 8'h00, 9, 8'hFC, 8'h00, DEST_C, 0, 0, 0, 0);
    wait_done("mul");
    issue(ALU_MUL, 1'b0, BSEL_B,   DEST_D, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 9, 8'h01, 8'hFE, DEST_D, 0, 1, 0, 0);
    wait_done("mul_ff");
    issue(ALU_DIV, 1'b0, BSEL_B,   DEST_D, 8'h64, 8'h07, 8'h00, 8'h00, 8'h00, 9, 8'h0E, 8'h02, DEST_D, 0, 0, 0, 0);
    wait_done("div");
    issue(ALU_DIV, 1'b0, BSEL_B,   DEST_A, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'hFF, 8'h64, DEST_A, 0, 0, 1, 0);
    wait_done("div_zero");
    issue(3'b101,  1'b0, BSEL_B,   DEST_B, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 4'h0,   1, 0, 0, 1);
    wait_done("illegal");
    issue(ALU_ADD, 1'b1, BSEL_EXT, DEST_C, 8'h11, 8'h00, 8'h00, 8'h00, 8'h80, 1, 8'h00, 8'h00, DEST_C, 1, 1, 0, 0);
    wait_done("add_ext_wrap");
    issue(ALU_SUB, 1'b0, BSEL_D,   DEST_D, 8'h33, 8'h00, 8'h00, 8'h33, 8'h00, 1, 8'h00, 8'h00, DEST_D, 1, 0, 0, 0);
    wait_done("sub_zero");
    issue(ALU_DIV, 1'b1, BSEL_C,   DEST_A, 8'h00, 8'h00, 8'h64, 8'h00, 8'h07, 9, 8'h00, 8'h07, DEST_A, 1, 0, 0, 0);
    wait_done("div_small");
    issue(ALU_MUL, 1'b1, BSEL_EXT, DEST_B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 9, 8'h00, 8'h01, DEST_B, 1, 1, 0, 0);
    wait_done("mul_ext_sq");

    // start re-asserted mid-MUL must be dropped: one done, busy unbroken
    issue(ALU_MUL, 1'b0, BSEL_D,   DEST_C, 8'h0C, 8'h00, 8'h00, 8'h15, 8'h00, 9, 8'hFC, 8'h00, DEST_C, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    alu_sel = ALU_ADD; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("mul_restart");
    repeat (12) @(negedge clk);

    // Leave non-zero outputs behind, then abort a DIV with reset at edge N+4
    issue(ALU_DIV, 1'b0, BSEL_B,   DEST_D, 8'h64, 8'h07, 8'h00, 8'h00, 8'h00, 9, 8'h0E, 8'h02, DEST_D, 0, 0, 0, 0);
    wait_done("div_pre_abort");
    issue(ALU_DIV, 1'b0, BSEL_B,   DEST_D, 8'h64, 8'h07, 8'h00, 8'h00, 8'h00, 9, 8'h0E, 8'h02, DEST_D, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, 8'h00);
    chk("abort_result_hi", result_hi, 8'h00);
    chk("abort_wr_en", wr_en, 4'h0);
    chk("abort_flags", {flag_zero, flag_carry, flag_dz, flag_illegal}, 4'b0000);
    rst = 1'b0;
    repeat (14) @(negedge clk);

    // Executor still usable after the abort
    issue(ALU_ADD, 1'b0, BSEL_C,   DEST_A, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 1, 8'h03, 8'h00, DEST_A, 0, 0, 0, 0);
    wait_done("add_post_abort");
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/arithmetic_executor.md
Name: arithmetic_executor

Overview:
- Multi-cycle execution unit on the controller→datapath boundary. Consumes the ALU control word produced by the arithmetic decoder (alu_sel, acc_sel, alu_b_sel, destination_reg_flag) and performs the operation.
- ADD/SUB complete in one cycle. MUL uses an iterative shift-add datapath; DIV uses iterative restoring division. Both run under a start/busy/done handshake with the sequencer.
- Drives the result, per-register write enables and status flags back to the register file.

Parameters:
- DATA_W, 8, operand/result width
- CNT_W, 4, iteration counter width (must hold DATA_W)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  launch operation; sampled only in IDLE
- alu_sel  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 1xx illegal
- acc_sel  in  1  operand A source: 0 = reg_a, 1 = ext_data
- alu_b_sel  in  2  operand B source: 00 ext_data, 01 reg_b, 10 reg_c, 11 reg_d
- destination_reg_flag  in  4  one-hot destination: bit0 A, bit1 B, bit2 C, bit3 D
- reg_a, reg_b, reg_c, reg_d  in  DATA_W each  register file read values
- ext_data  in  DATA_W  memory/immediate operand
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle completion pulse
- result  out  DATA_W  sum/difference/product low byte/quotient
- result_hi  out  DATA_W  product high byte / remainder; 0 for ADD/SUB
- wr_en  out  4  destination_reg_flag latched at start; driven only while done=1, else 0
- flag_zero  out  1  result == 0; updated with done
- flag_carry  out  1  ADD: carry-out; SUB: borrow (A<B); MUL: result_hi != 0; DIV: 0
- flag_dz  out  1  divide-by-zero; updated with done
- flag_illegal  out  1  illegal alu_sel; updated with done

Behaviour:
- Reset:
  - State = IDLE.
  - busy, done, wr_en, result, result_hi and all flags = 0.
  - Reset mid-operation aborts immediately. No done pulse and no write follow.
- Start acceptance:
  - At the start edge in IDLE, latch operand A, operand B, alu_sel and destination_reg_flag.
  - Inputs may change afterwards without effect.
  - start while busy or in DONE is ignored. It is not queued.
- States:
  - IDLE → EXEC when alu_sel is ADD/SUB/illegal, or DIV with B = 0.
  - IDLE → ITER when alu_sel is MUL, or DIV with B ≠ 0.
  - ITER → ITER for DATA_W cycles, tracked by a counter running 0..DATA_W-1. ITER → DONE when the counter reaches DATA_W-1.
  - EXEC → IDLE and DONE → IDLE, each with done = 1 for one cycle.
- Latency, with start sampled at edge N:
  - ADD/SUB, illegal and divide-by-zero: done at cycle N+1.
  - MUL/DIV: done at cycle N+DATA_W+1 (N+9 for the default width).
  - busy is high from N+1 through the done cycle inclusive.
  - A new start is accepted in the cycle after done, giving back-to-back throughput.
- Arithmetic (all unsigned):
  - ADD: {carry, result} = A + B, computed at DATA_W+1 bits.
  - SUB: result = A − B mod 2^DATA_W; borrow = A < B.
  - MUL: 16-bit product {result_hi, result}. Each iteration, if the multiplier LSB is 1, add the multiplicand to the upper half, then shift right.
  - DIV: restoring division, one quotient bit per cycle, MSB first. result = quotient, result_hi = remainder.
  - DIV with B = 0: result = all ones, result_hi = A, flag_dz = 1, wr_en = destination_reg_flag.
  - Illegal alu_sel: result = 0, result_hi = 0, wr_en = 0, flag_illegal = 1.
- Output hold:
  - result, result_hi and flags are registered at done and held until the next done.
  - wr_en and done are 0 outside the done cycle.

Decomposition:
- Shared package / include holds:
  - ALU_ADD/SUB/MUL/DIV encodings
  - B-source encodings
  - destination one-hot constants
  - state encodings IDLE/EXEC/ITER/DONE
  - These must match the decoder's encodings exactly.
- One sub-module: arith_iter_core. It owns the shift registers and counter for MUL/DIV, with inputs load/is_div/op_a/op_b and outputs lo/hi/last.
- The top level owns operand muxing, the FSM, ADD/SUB and the flags.

Test Plan:
- ADD: reg_a = 0xF0, reg_b = 0x20, alu_sel = 000, alu_b_sel = 01, dest = 0001, start at N → done at N+1; result = 0x10, flag_carry = 1, flag_zero = 0, wr_en = 0001.
- SUB: reg_a = 0x05, reg_c = 0x07, alu_b_sel = 10 → result = 0xFE, flag_carry = 1 (borrow), result_hi = 0.
- MUL: reg_a = 0x0C, reg_d = 0x15, alu_sel = 010 → done exactly at N+9, busy high N+1..N+9; result = 0xFC, result_hi = 0x00, flag_carry = 0.
  - Repeat with 0xFF × 0xFF → result = 0x01, result_hi = 0xFE, flag_carry = 1.
- DIV: reg_a = 0x64, reg_b = 0x07 → done at N+9; result = 0x0E, result_hi = 0x02.
  - DIV by reg_b = 0x00 → done at N+1; result = 0xFF, result_hi = 0x64, flag_dz = 1.
- Handshake and abort:
  - start re-asserted during a MUL at N+3 is ignored; exactly one done pulse occurs.
  - rst asserted at N+4 of a DIV → busy = 0, all outputs 0 next cycle, no done pulse.
  - alu_sel = 101 → done at N+1, wr_en = 0000, flag_illegal = 1.
